// File: rtl/iddmm_div_pkg.sv
// Shared definitions for the radix-2 restoring divider: FSM states and default widths.
package iddmm_div_pkg;

   localparam int DW_DEFAULT = 256;
   localparam int VW_DEFAULT = 128;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/iddmm_div_step.sv
// One restoring-division step: shift in the next dividend bit, compare against
// the divisor, and subtract when it fits.
module iddmm_div_step
   import iddmm_div_pkg::*;
#(
   parameter int VW = VW_DEFAULT
) (
   input  logic [VW:0]   rem_in,
   input  logic          bit_in,
   input  logic [VW-1:0] divisor,
   output logic [VW:0]   rem_out,
   output logic          q_bit
);

   logic [VW:0] shifted;
   logic [VW:0] diff;

   // rem_in[VW] is the bit shifted out; when set the shifted value certainly exceeds the divisor
   assign shifted = {rem_in[VW-1:0], bit_in};
   assign diff    = shifted - {1'b0, divisor};
   assign q_bit   = rem_in[VW] | (shifted >= {1'b0, divisor});
   assign rem_out = q_bit ? diff : shifted;

endmodule

// File: rtl/iddmm_div_256_by_128.sv
// Sequential unsigned divider, one quotient bit per clock, MSB first, with a
// valid/ready handshake on both the operand and the result side.
module iddmm_div_256_by_128
   import iddmm_div_pkg::*;
#(
   parameter int DW = DW_DEFAULT,
   parameter int VW = VW_DEFAULT
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          div_zero
);

   localparam int CW = $clog2(DW);

   state_t        state_reg;
   state_t        state_next;
   logic [CW-1:0] cnt_reg;
   logic [VW:0]   prem_reg;
   logic [DW-1:0] dq_reg;
   logic [VW-1:0] divisor_reg;
   logic          div_zero_reg;
   logic          settle_reg;

   logic          accept;
   logic [VW:0]   prem_step;
   logic          q_bit;

   assign accept = in_valid && in_ready;

   iddmm_div_step #(
      .VW (VW)
   ) u_step (
      .rem_in  (prem_reg),
      .bit_in  (dq_reg[DW-1]),
      .divisor (divisor_reg),
      .rem_out (prem_step),
      .q_bit   (q_bit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               state_next = (divisor == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            if (cnt_reg == '0) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (out_valid && out_ready) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A zero-divisor result is held back one cycle so it appears one clock after acceptance
   always_comb begin
      in_ready  = (state_reg == IDLE);
      out_valid = (state_reg == DONE) && !settle_reg;
   end

   // dq_reg shifts the dividend out of its MSB while quotient bits enter at the LSB
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg      <= '0;
         prem_reg     <= '0;
         dq_reg       <= '0;
         divisor_reg  <= '0;
         div_zero_reg <= 1'b0;
         settle_reg   <= 1'b0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (accept) begin
                  divisor_reg <= divisor;
                  if (divisor == '0) begin
                     dq_reg       <= '1;
                     prem_reg     <= {1'b0, dividend[VW-1:0]};
                     div_zero_reg <= 1'b1;
                     settle_reg   <= 1'b1;
                     cnt_reg      <= '0;
                  end else begin
                     dq_reg       <= dividend;
                     prem_reg     <= '0;
                     div_zero_reg <= 1'b0;
                     settle_reg   <= 1'b0;
                     cnt_reg      <= CW'(DW - 1);
                  end
               end
            end
            RUN: begin
               prem_reg <= prem_step;
               dq_reg   <= {dq_reg[DW-2:0], q_bit};
               if (cnt_reg != '0) begin
                  cnt_reg <= cnt_reg - 1'b1;
               end
            end
            DONE: begin
               settle_reg <= 1'b0;
            end
            default: begin
               settle_reg <= 1'b0;
            end
         endcase
      end
   end

   assign quotient  = dq_reg;
   assign remainder = prem_reg[VW-1:0];
   assign div_zero  = div_zero_reg;

endmodule

// File: tb/tb_iddmm_div_256_by_128.sv
// Directed and randomised checks of the 256/128 sequential divider.
module tb_iddmm_div_256_by_128;

   localparam int DW      = 256;
   localparam int VW      = 128;
   localparam int TIMEOUT = 600;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          div_zero;

   int checks   = 0;
   int failures = 0;

   iddmm_div_256_by_128 #(
      .DW (DW),
      .VW (VW)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rand_dw();
      logic [DW-1:0] r;
      for (int j = 0; j < DW / 32; j++) r[j*32 +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [VW-1:0] rand_vw();
      logic [VW-1:0] r;
      for (int j = 0; j < VW / 32; j++) r[j*32 +: 32] = $urandom;
      r = r >> $urandom_range(0, VW - 1);
      if (r == '0) r = 1;
      return r;
   endfunction

   // Handshake edge is the posedge inside; returns #1 after it
   task automatic start_op(input logic [DW-1:0] a, input logic [VW-1:0] b);
      @(negedge clk);
      dividend = a;
      divisor  = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int cycles);
      cycles = 0;
      while (out_valid !== 1'b1 && cycles < TIMEOUT) begin
         @(posedge clk);
         #1;
         cycles++;
      end
   endtask

   task automatic release_result();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      dividend  = '0;
      divisor   = '0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (quotient !== '0 || remainder !== '0 || div_zero !== 1'b0 || out_valid !== 1'b0) begin
         $display("FAIL reset_outputs: q=%h r=%h dz=%b ov=%b, required all zero",
                  quotient, remainder, div_zero, out_valid);
         failures++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
         $display("FAIL reset_in_ready: got %b, required 1", in_ready);
         failures++;
      end
      $display("reset: in_ready=%b out_valid=%b", in_ready, out_valid);
   endtask

   task automatic test_basic();
      int cyc;
      start_op(1000, 7);
      wait_done(cyc);
      $display("1000/7: q=%0d r=%0d dz=%b latency=%0d", quotient, remainder, div_zero, cyc);
      checks++;
      if (cyc != DW) begin
         $display("FAIL basic_latency: got %0d, required %0d", cyc, DW);
         failures++;
      end
      checks++;
      if (quotient !== 142) begin
         $display("FAIL basic_quotient: got %0d, required 142", quotient);
         failures++;
      end
      checks++;
      if (remainder !== 6 || div_zero !== 1'b0) begin
         $display("FAIL basic_remainder: got r=%0d dz=%b, required r=6 dz=0", remainder, div_zero);
         failures++;
      end
      release_result();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         $display("FAIL basic_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
         failures++;
      end
   endtask

   task automatic test_extremes();
      int cyc;
      logic [DW-1:0] exp_q;
      start_op({DW{1'b1}}, 1);
      wait_done(cyc);
      $display("max/1: q=%h r=%h latency=%0d", quotient, remainder, cyc);
      checks++;
      if (quotient !== {DW{1'b1}} || remainder !== '0 || cyc != DW) begin
         $display("FAIL max_div_one: q=%h r=%h lat=%0d, required all ones, 0, %0d",
                  quotient, remainder, cyc, DW);
         failures++;
      end
      release_result();
      exp_q = {{(DW-VW-1){1'b0}}, 1'b1, {(VW-1){1'b0}}, 1'b1};
      start_op({DW{1'b1}}, {VW{1'b1}});
      wait_done(cyc);
      $display("max/maxv: q=%h r=%h latency=%0d", quotient, remainder, cyc);
      checks++;
      if (quotient !== exp_q || remainder !== '0 || cyc != DW) begin
         $display("FAIL max_div_maxv: q=%h r=%h lat=%0d, required %h, 0, %0d",
                  quotient, remainder, cyc, exp_q, DW);
         failures++;
      end
      release_result();
   endtask

   task automatic test_div_zero();
      int cyc;
      start_op(256'h1234, '0);
      wait_done(cyc);
      $display("0x1234/0: q=%h r=%h dz=%b latency=%0d", quotient, remainder, div_zero, cyc);
      checks++;
      if (cyc != 1) begin
         $display("FAIL divzero_latency: got %0d, required 1", cyc);
         failures++;
      end
      checks++;
      if (div_zero !== 1'b1 || quotient !== {DW{1'b1}} || remainder !== 128'h1234) begin
         $display("FAIL divzero_result: dz=%b q=%h r=%h, required 1, all ones, 1234",
                  div_zero, quotient, remainder);
         failures++;
      end
      release_result();
   endtask

   task automatic test_backpressure();
      int cyc;
      int bad;
      start_op(5, 9);
      wait_done(cyc);
      $display("5/9: q=%0d r=%0d latency=%0d", quotient, remainder, cyc);
      checks++;
      if (quotient !== 0 || remainder !== 5 || div_zero !== 1'b0 || cyc != DW) begin
         $display("FAIL small_result: q=%0d r=%0d dz=%b lat=%0d, required 0, 5, 0, %0d",
                  quotient, remainder, div_zero, cyc, DW);
         failures++;
      end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         dividend = rand_dw();
         divisor  = 3;
         @(posedge clk);
         #1;
         if (quotient !== 0 || remainder !== 5 || div_zero !== 1'b0 ||
             out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      in_valid = 1'b0;
      $display("5/9 held: q=%0d r=%0d ov=%b ir=%b", quotient, remainder, out_valid, in_ready);
      checks++;
      if (bad != 0) begin
         $display("FAIL hold_stable: %0d unstable cycles, required 0", bad);
         failures++;
      end
      release_result();
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         $display("FAIL hold_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
         failures++;
      end
   endtask

   task automatic test_reset_mid_run();
      int spurious;
      start_op(1000, 7);
      repeat (100) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      $display("reset at step 100: q=%h r=%h ov=%b", quotient, remainder, out_valid);
      checks++;
      if (quotient !== '0 || remainder !== '0 || div_zero !== 1'b0 ||
          out_valid !== 1'b0 || in_ready !== 1'b1) begin
         $display("FAIL midrun_reset: q=%h r=%h dz=%b ov=%b ir=%b, required 0,0,0,0,1",
                  quotient, remainder, div_zero, out_valid, in_ready);
         failures++;
      end
      @(negedge clk);
      rst_n = 1'b1;
      spurious = 0;
      repeat (300) begin
         @(posedge clk);
         #1;
         if (out_valid !== 1'b0 || in_ready !== 1'b1) spurious++;
      end
      checks++;
      if (spurious != 0) begin
         $display("FAIL midrun_spurious: %0d bad cycles, required 0", spurious);
         failures++;
      end
      test_basic();
   endtask

   task automatic test_back_to_back();
      logic [DW-1:0]    a;
      logic [VW-1:0]    b;
      logic [DW-1:0]    exp_q;
      logic [DW-1:0]    exp_r;
      logic [DW+VW-1:0] recon;
      int cyc;
      a = rand_dw();
      b = rand_vw();
      start_op(a, b);
      for (int i = 0; i < 6; i++) begin
         wait_done(cyc);
         exp_q = a / {{(DW-VW){1'b0}}, b};
         exp_r = a % {{(DW-VW){1'b0}}, b};
         $display("rand %0d: a=%h b=%h q=%h r=%h latency=%0d", i, a, b, quotient, remainder, cyc);
         checks++;
         if (cyc != DW) begin
            $display("FAIL rand_latency: got %0d, required %0d", cyc, DW);
            failures++;
         end
         checks++;
         if (quotient !== exp_q) begin
            $display("FAIL rand_quotient: got %h, required %h", quotient, exp_q);
            failures++;
         end
         checks++;
         if (remainder !== exp_r[VW-1:0]) begin
            $display("FAIL rand_remainder: got %h, required %h", remainder, exp_r[VW-1:0]);
            failures++;
         end
         recon = {{VW{1'b0}}, quotient} * {{DW{1'b0}}, b} + {{DW{1'b0}}, remainder};
         checks++;
         assert (remainder < b && recon == {{VW{1'b0}}, a})
         else begin
            $display("FAIL rand_identity: q*d+r=%h r=%h, required %h with r<%h", recon, remainder, a, b);
            failures++;
         end
         repeat ($urandom_range(0, 4)) @(posedge clk);
         if (i < 5) begin
            a = rand_dw();
            b = rand_vw();
            @(negedge clk);
            out_ready = 1'b1;
            in_valid  = 1'b1;
            dividend  = a;
            divisor   = b;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
               $display("FAIL no_same_cycle_accept: in_ready=%b out_valid=%b, required 1/0",
                        in_ready, out_valid);
               failures++;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
         end else begin
            release_result();
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_div_zero();
      test_backpressure();
      test_reset_mid_run();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule

// File: doc/iddmm_div_256_by_128.md
IDDMM_DIV_256_BY_128 -- requirements
Module: iddmm_div_256_by_128

Interface
REQ-001 Parameter DW, default 256: dividend and quotient width in bits.
REQ-002 Parameter VW, default 128: divisor and remainder width in bits; DW SHALL be at least VW.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  dividend/divisor present.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 dividend  input  DW  unsigned numerator, sampled at input handshake.
REQ-008 divisor  input  VW  unsigned denominator, sampled at input handshake.
REQ-009 out_valid  output  1  result present.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 quotient  output  DW  floor(dividend/divisor).
REQ-012 remainder  output  VW  dividend mod divisor.
REQ-013 div_zero  output  1  divisor was zero for the current result.

Function
REQ-014 The block SHALL be a restoring radix-2 divider: one quotient bit per clock, MSB first, with a partial remainder VW+1 bits wide.
REQ-015 FSM states SHALL be IDLE, RUN and DONE; the reset state SHALL be IDLE.
REQ-016 in_ready SHALL be 1 only in IDLE; an input handshake is in_valid && in_ready at a rising edge.
REQ-017 IDLE->RUN on handshake with divisor!=0: latch the operands, clear the partial remainder, and load the bit counter with DW-1.
REQ-018 IDLE->DONE on handshake with divisor==0: quotient = all ones, remainder = dividend[VW-1:0], div_zero=1, with no RUN cycles.
REQ-019 RUN step: shift the next dividend bit into the remainder LSB; if the result >= divisor, subtract and set the quotient bit to 1, else keep it and set 0; decrement the counter.
REQ-020 RUN->DONE on the step where the counter equals 0; exactly DW RUN steps SHALL occur.
REQ-021 Latency: for a handshake at edge k, out_valid SHALL be 1 immediately after edge k+DW (nonzero divisor) or edge k+1 (zero divisor).
REQ-022 out_valid SHALL be 1 only in DONE; quotient, remainder and div_zero SHALL stay stable while out_valid && !out_ready.
REQ-023 DONE->IDLE on out_valid && out_ready; in_ready rises in the following cycle, with no same-cycle re-accept.
REQ-024 in_valid during RUN or DONE SHALL be ignored, and the operands SHALL not be re-sampled.
REQ-025 The remainder output SHALL be strictly less than divisor, and quotient*divisor+remainder SHALL equal dividend for every nonzero divisor.

Reset
REQ-026 On rst_n low, asynchronously: state=IDLE, counter=0, partial remainder=0, quotient=0, remainder=0, div_zero=0, out_valid=0; in_ready SHALL be 1 after reset release.
REQ-027 Reset asserted mid-RUN or mid-DONE SHALL abort the operation; no out_valid SHALL follow reset release without a new handshake.

Structure
REQ-028 The shared package iddmm_div_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the default DW/VW constants.
REQ-029 One combinational sub-module, iddmm_div_step, SHALL implement a single shift/compare/subtract step (inputs: remainder, next bit, divisor; outputs: new remainder, quotient bit).
REQ-030 Counter width SHALL be $clog2(DW).

Verification
REQ-031 dividend=1000, divisor=7 -> quotient=142, remainder=6, div_zero=0, out_valid 256 cycles after the handshake.
REQ-032 dividend=2^256-1, divisor=1 -> quotient=2^256-1, remainder=0; then divisor=2^128-1 -> quotient=2^128+1, remainder=0.
REQ-033 divisor=0, dividend=0x1234 -> div_zero=1, quotient all ones, remainder=0x1234, out_valid one cycle after the handshake.
REQ-034 dividend=5, divisor=9 -> quotient=0, remainder=5; hold out_ready=0 for 10 cycles -> outputs stable, in_ready=0, extra in_valid ignored.
REQ-035 rst_n pulsed low at RUN step 100 -> outputs cleared at once, in_ready=1 after release, no spurious out_valid; the next operation is correct.
REQ-036 Random back-to-back operations with random out_ready against a reference model -> every quotient/remainder matches, with REQ-025 checked by assertion.
